// File: rtl/piano_pkg.sv
// Shared constants and types for the piano datapath front-end.
package piano_pkg;

  localparam int NUM_KEYS_DEFAULT = 7;
  localparam int NOTE_W           = 4;
  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;

  // Short debounce window used when simulating the key path.
  localparam int DEBOUNCE_SIM = 4;

  typedef logic [NOTE_W-1:0] note_t;

endpackage : piano_pkg

// File: rtl/debounce_cell.sv
// Single-bit key conditioner: 2-FF synchroniser, stability counter and
// committed clean level. The clean level only moves after DEBOUNCE_CYCLES
// consecutive synchronised samples that disagree with it.
module debounce_cell
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int CNT_W           = 21
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous switch into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  // Count disagreeing samples; any agreement restarts the window, and a full
  // window commits the new level. The counter clears on both paths, so it
  // never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (sync_p1 == dout) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      dout <= sync_p1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule : debounce_cell

// File: rtl/key_conditioner.sv
// Key front-end: debounces every raw key, then derives registered
// press/release strobes and a lowest-key-wins note code for the Controller.
module key_conditioner
  import piano_pkg::*;
#(
  parameter int NUM_KEYS        = NUM_KEYS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int CNT_W           = 21
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys_raw,
  output logic [NUM_KEYS-1:0] keys_clean,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NOTE_W-1:0]   note_code,
  output logic                note_change
);

  // The 4-bit note code reserves 0 for rest, leaving room for 15 keys.
  if (NUM_KEYS < 1 || NUM_KEYS > 15) begin : g_bad_num_keys
    $error("key_conditioner: NUM_KEYS must be in 1..15");
  end
  if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
    $error("key_conditioner: CNT_W too narrow for DEBOUNCE_CYCLES");
  end

  // Lowest held key wins; its index is reported one-based.
  function automatic note_t lowest_note(input logic [NUM_KEYS-1:0] keys);
    note_t code;
    code = NOTE_REST;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) code = NOTE_W'(i + 1);
    end
    return code;
  endfunction

  logic [NUM_KEYS-1:0] prev_clean;
  note_t               note_next;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_cell (
      .clk  (clk),
      .reset(reset),
      .din  (keys_raw[g]),
      .dout (keys_clean[g])
    );
  end

  // Encode the current clean levels ahead of the output register.
  always_comb begin
    note_next = lowest_note(keys_clean);
  end

  // Edge strobes and note tracking, all registered one cycle after keys_clean.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_clean  <= '0;
      key_press   <= '0;
      key_release <= '0;
      note_code   <= NOTE_REST;
      note_change <= 1'b0;
    end else begin
      prev_clean  <= keys_clean;
      key_press   <= keys_clean & ~prev_clean;
      key_release <= ~keys_clean & prev_clean;
      note_code   <= note_next;
      note_change <= (note_next != note_code);
    end
  end

endmodule : key_conditioner

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with a 4-cycle debounce window.
// A raw change applied between edges commits to keys_clean 6 edges later
// (2 synchroniser + 4 debounce); strobes and note_code follow one edge after.
module tb_key_conditioner;

  localparam int NK  = 7;
  localparam int DEB = 4;
  localparam int CW  = 3;

  logic          clk;
  logic          reset;
  logic [NK-1:0] keys_raw;
  logic [NK-1:0] keys_clean;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [3:0]    note_code;
  logic          note_change;

  int checks   = 0;
  int failures = 0;

  key_conditioner #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .keys_raw   (keys_raw),
    .keys_clean (keys_clean),
    .key_press  (key_press),
    .key_release(key_release),
    .note_code  (note_code),
    .note_change(note_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int press_cnt;
  int chg_cnt;
  logic [NK-1:0] seen_clean;
  logic [NK-1:0] seen_press;

  initial begin
    // ---- 1. reset behaviour, all keys held through reset ----
    reset    = 1'b0;
    keys_raw = 7'h7F;
    tick(3);
    check("rst_clean",   32'(keys_clean),  32'h0);
    check("rst_press",   32'(key_press),   32'h0);
    check("rst_release", 32'(key_release), 32'h0);
    check("rst_note",    32'(note_code),   32'h0);
    check("rst_change",  32'(note_change), 32'h0);
    reset = 1'b1;
    tick(5);
    check("t1_clean_early", 32'(keys_clean), 32'h0);
    tick(1);
    check("t1_clean",       32'(keys_clean), 32'h7F);
    check("t1_press_early", 32'(key_press),  32'h0);
    tick(1);
    check("t1_press",  32'(key_press),   32'h7F);
    check("t1_note",   32'(note_code),   32'h1);
    check("t1_change", 32'(note_change), 32'h1);
    tick(1);
    check("t1_press_end",  32'(key_press),   32'h0);
    check("t1_change_end", 32'(note_change), 32'h0);
    check("t1_note_hold",  32'(note_code),   32'h1);

    // release everything before the bounce test
    keys_raw = 7'h00;
    tick(6);
    check("t1_rel_clean", 32'(keys_clean), 32'h0);
    tick(1);
    check("t1_release",     32'(key_release), 32'h7F);
    check("t1_rel_note",    32'(note_code),   32'h0);
    check("t1_rel_change",  32'(note_change), 32'h1);
    tick(2);

    // ---- 2. bounce rejection on key 3 ----
    press_cnt  = 0;
    seen_clean = '0;
    for (int r = 0; r < 3; r++) begin
      keys_raw[3] = 1'b1;
      tick(1); seen_clean |= keys_clean; press_cnt += int'(key_press[3]);
      tick(1); seen_clean |= keys_clean; press_cnt += int'(key_press[3]);
      keys_raw[3] = 1'b0;
      tick(1); seen_clean |= keys_clean; press_cnt += int'(key_press[3]);
    end
    check("t2_bounce_clean", 32'(seen_clean), 32'h0);
    keys_raw[3] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1); seen_clean |= keys_clean; press_cnt += int'(key_press[3]);
    end
    check("t2_clean_early", 32'(seen_clean), 32'h0);
    tick(1); press_cnt += int'(key_press[3]);
    check("t2_clean", 32'(keys_clean), 32'h08);
    tick(1); press_cnt += int'(key_press[3]);
    check("t2_press",  32'(key_press),   32'h08);
    check("t2_note",   32'(note_code),   32'h4);
    check("t2_change", 32'(note_change), 32'h1);
    for (int k = 0; k < 4; k++) begin
      tick(1); press_cnt += int'(key_press[3]);
    end
    check("t2_press_count", 32'(press_cnt), 32'd1);

    // ---- 3. chord priority with keys 5 and 2 ----
    keys_raw = 7'h00;
    tick(7);
    check("t3_rest", 32'(note_code), 32'h0);
    keys_raw = 7'h20;
    tick(7);
    check("t3_k5_note",   32'(note_code),   32'h6);
    check("t3_k5_change", 32'(note_change), 32'h1);
    tick(1);
    keys_raw = 7'h24;
    tick(7);
    check("t3_k2_note",   32'(note_code),   32'h3);
    check("t3_k2_change", 32'(note_change), 32'h1);
    check("t3_k2_press",  32'(key_press),   32'h04);
    tick(1);
    keys_raw = 7'h20;
    tick(7);
    check("t3_k2rel_note",   32'(note_code),   32'h6);
    check("t3_k2rel_change", 32'(note_change), 32'h1);
    check("t3_k2rel_rel",    32'(key_release), 32'h04);
    tick(1);
    keys_raw = 7'h00;
    tick(7);
    check("t3_k5rel_note",   32'(note_code),   32'h0);
    check("t3_k5rel_change", 32'(note_change), 32'h1);
    check("t3_k5rel_rel",    32'(key_release), 32'h20);
    tick(1);
    check("t3_change_end", 32'(note_change), 32'h0);

    // ---- 4. 3-cycle glitch on key 0 is ignored ----
    seen_clean = '0;
    seen_press = '0;
    chg_cnt    = 0;
    keys_raw[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) keys_raw[0] = 1'b0;
      tick(1);
      seen_clean |= keys_clean;
      seen_press |= key_press;
      chg_cnt    += int'(note_change);
    end
    check("t4_clean",  32'(seen_clean), 32'h0);
    check("t4_press",  32'(seen_press), 32'h0);
    check("t4_change", 32'(chg_cnt),    32'd0);

    // ---- 5. simultaneous release of key 1 and press of key 4 ----
    keys_raw = 7'h02;
    tick(7);
    check("t5_k1_note", 32'(note_code), 32'h2);
    tick(1);
    keys_raw = 7'h10;
    chg_cnt  = 0;
    tick(6);
    chg_cnt += int'(note_change);
    tick(1);
    chg_cnt += int'(note_change);
    check("t5_release", 32'(key_release), 32'h02);
    check("t5_press",   32'(key_press),   32'h10);
    check("t5_note",    32'(note_code),   32'h5);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chg_cnt += int'(note_change);
    end
    check("t5_change_count", 32'(chg_cnt), 32'd1);

    // ---- 6. reset mid-count on key 6, key 4 still held ----
    keys_raw = 7'h50;
    tick(4);
    check("t6_pre_clean", 32'(keys_clean), 32'h10);
    reset = 1'b0;
    #2;
    check("t6_async_clean", 32'(keys_clean), 32'h0);
    check("t6_async_note",  32'(note_code),  32'h0);
    tick(1);
    reset = 1'b1;
    tick(5);
    check("t6_clean_early", 32'(keys_clean), 32'h0);
    tick(1);
    check("t6_clean", 32'(keys_clean), 32'h50);
    tick(1);
    check("t6_press",  32'(key_press),   32'h50);
    check("t6_note",   32'(note_code),   32'h5);
    check("t6_change", 32'(note_change), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_key_conditioner
